cache_drain_ctrl: RTL and testbench

Read-side controller for the cache buffer; drains the entries that the write-side cache counter has accumulated. On a start pulse it samples the fill level and reads cache addresses 0..N-1 from the single-port cache SRAM (1-cycle read latency). It streams each word downstream over a valid/ready handshake through a 2-entry skid buffer. When the last word is accepted it pulses done and clears the write-side fill counter.

---
 rtl/cache_drain_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cache_drain_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_drain_ctrl.sv
// cache_drain_ctrl
//
// Read-side drain controller for the cache buffer. A start pulse samples the
// write-side fill level, reads cache addresses 0..len-1 from a single-port
// SRAM with 1-cycle read latency and streams the words downstream over a
// valid/ready handshake through a 2-entry skid FIFO. When the final word is
// accepted, done and clear_fill pulse together for one cycle.
//
// Optional feature macro: CACHE_DRAIN_PARITY_EN adds o_parity_out, the running
// XOR of every word accepted downstream during the current drain.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_start        drain request pulse, ignored unless idle
//   i_abort        cancel an active drain (no done / clear_fill)
//   i_fill_count   number of valid cache entries, sampled on accepted start
//   o_rd_en        cache read strobe
//   o_rd_addr      cache read address
//   i_rd_data      cache read data, valid the cycle after o_rd_en
//   o_out_valid    o_out_data holds a drained word
//   i_out_ready    downstream accept
//   o_out_data     drained word
//   o_busy         drain in progress
//   o_done         one-cycle pulse, final word accepted
//   o_clear_fill   one-cycle pulse clearing the write-side counter
//   o_parity_out   (CACHE_DRAIN_PARITY_EN only) running XOR of accepted words

module cache_drain_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_fill_count,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_clear_fill
`ifdef CACHE_DRAIN_PARITY_EN
  ,
  output logic [DATA_W-1:0] o_parity_out
`endif
);

  typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_inflight;
  logic [DATA_W-1:0] r_mem [2];
  logic              r_head;
  logic              r_tail;
  logic [1:0]        r_occ;
  logic              r_busy;
  logic              r_done;
  logic              r_clear;
  logic [DATA_W-1:0] r_parity;

  logic [1:0]        w_level;
  logic              w_rd_en;
  logic              w_out_valid;
  logic [DATA_W-1:0] w_out_data;
  logic              w_pop;
  logic              w_pop_fifo;
  logic              w_push;
  logic              w_last_issue;
  logic              w_final_pop;

  // Words owned by the drain path: buffered plus the one returning this cycle.
  assign w_level     = r_occ + {1'b0, r_inflight};
  assign w_rd_en     = (r_state == StRead) && (w_level < 2'd2);
  assign w_out_valid = (r_occ != 2'd0) || r_inflight;

  // With the FIFO empty the returning SRAM word is presented directly, so the
  // first word appears the cycle after its read without an extra stage.
  always_comb begin
    w_out_data = '0;
    if (r_occ != 2'd0) begin
      w_out_data = r_mem[r_head];
    end else if (r_inflight) begin
      w_out_data = i_rd_data;
    end
  end

  assign w_pop        = w_out_valid && i_out_ready;
  assign w_pop_fifo   = w_pop && (r_occ != 2'd0);
  // A bypassed word that is accepted at once never enters the FIFO.
  assign w_push       = r_inflight && !(w_pop && (r_occ == 2'd0));
  assign w_last_issue = w_rd_en && (r_rd_ptr == r_len - ADDR_W'(1));
  assign w_final_pop  = w_pop && (w_level == 2'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_len      <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_occ      <= 2'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clear    <= 1'b0;
      r_parity   <= '0;
    end else if (i_abort && (r_state != StIdle)) begin
      // Any word still returning from the SRAM is discarded with inflight.
      r_state    <= StIdle;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_occ      <= 2'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_clear    <= 1'b0;
      r_parity   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_clear    <= 1'b0;
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_push) begin
        r_mem[r_tail] <= i_rd_data;
        r_tail        <= ~r_tail;
      end
      if (w_pop_fifo) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop_fifo};
      if (w_pop) begin
        r_parity <= r_parity ^ w_out_data;
      end

      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_len    <= i_fill_count;
            r_rd_ptr <= '0;
            r_parity <= '0;
            r_busy   <= 1'b1;
            if (i_fill_count != '0) begin
              r_state <= StRead;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_clear <= 1'b1;
            end
          end
        end
        StRead: begin
          if (w_last_issue) begin
            r_state <= StFlush;
          end
        end
        StFlush: begin
          if (w_final_pop) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_clear <= 1'b1;
          end
        end
        StDone: begin
          r_state  <= StIdle;
          r_busy   <= 1'b0;
          r_rd_ptr <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rd_en      = w_rd_en;
  assign o_rd_addr    = r_rd_ptr;
  assign o_out_valid  = w_out_valid;
  assign o_out_data   = w_out_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_clear_fill = r_clear;

`ifdef CACHE_DRAIN_PARITY_EN
  assign o_parity_out = r_parity;
`else
  logic w_unused_parity;
  assign w_unused_parity = ^r_parity;
`endif

endmodule

// File: tb/tb_cache_drain_ctrl.sv
// Directed testbench for cache_drain_ctrl with a behavioural 1-cycle SRAM.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_cache_drain_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] fill;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic       clear_fill;
`ifdef CACHE_DRAIN_PARITY_EN
  logic [7:0] parity_out;
`endif

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;

  cache_drain_ctrl #(
    .ADDR_W(8),
    .DATA_W(8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_abort      (abort),
    .i_fill_count (fill),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_clear_fill (clear_fill)
`ifdef CACHE_DRAIN_PARITY_EN
    ,
    .o_parity_out (parity_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial rd_data = 8'h00;
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_rd_en"}, 32'(rd_en), 32'd0);
    check_eq({pfx, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check_eq({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({pfx, "_out_data"}, 32'(out_data), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_done"}, 32'(done), 32'd0);
    check_eq({pfx, "_clear"}, 32'(clear_fill), 32'd0);
  endtask

  initial begin
    int idx;
    int issued;
    bit done_seen;
    bit prev_stall;
    bit rdy;

    rst = 1'b1; start = 1'b0; abort = 1'b0; fill = 8'd0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic drain, len=4, no backpressure.
    fill = 8'd4; out_ready = 1'b1; start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("basic_rd_en", 32'(rd_en), 32'(k <= 4));
      if (k <= 4) check_eq("basic_rd_addr", 32'(rd_addr), 32'(k - 1));
      check_eq("basic_valid", 32'(out_valid), 32'(k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check_eq("basic_data", 32'(out_data), 32'(16 + k - 2));
      check_eq("basic_done", 32'(done), 32'(k == 6));
      check_eq("basic_clear", 32'(clear_fill), 32'(k == 6));
      check_eq("basic_busy", 32'(busy), 32'(k <= 6));
    end
    repeat (2) @(negedge clk);

    // Backpressure, len=6, ready pattern 1,0,0,1 repeating.
    fill = 8'd6; start = 1'b1;
    idx = 0; issued = 0; done_seen = 1'b0; prev_stall = 1'b0;
    for (int c = 1; c <= 60 && !done_seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      rdy = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
      out_ready = rdy;
      if (prev_stall) check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      if (rd_en) begin
        check_eq("bp_rd_addr", 32'(rd_addr), 32'(issued));
        check_eq("bp_outstanding", 32'((issued - idx) <= 1), 32'd1);
        issued++;
      end
      if (out_valid) begin
        check_eq("bp_data", 32'(out_data), 32'(16 + idx));
        if (rdy) idx++;
      end
      prev_stall = out_valid && !rdy;
      if (done) begin
        done_seen = 1'b1;
        check_eq("bp_words", 32'(idx), 32'd6);
        check_eq("bp_reads", 32'(issued), 32'd6);
        check_eq("bp_clear", 32'(clear_fill), 32'd1);
      end
    end
    check_eq("bp_done_seen", 32'(done_seen), 32'd1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length start.
    fill = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("zero_rd_en_t1", 32'(rd_en), 32'd0);
    check_eq("zero_done_t1", 32'(done), 32'd1);
    check_eq("zero_clear_t1", 32'(clear_fill), 32'd1);
    check_eq("zero_busy_t1", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("zero_rd_en_t2", 32'(rd_en), 32'd0);
    check_eq("zero_done_t2", 32'(done), 32'd0);
    check_eq("zero_busy_t2", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // Abort mid-drain at T4, then a fresh len=2 drain.
    fill = 8'd8; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("abort_pre_done", 32'(done), 32'd0);
      if (k == 4) begin
        check_eq("abort_pre_data", 32'(out_data), 32'h12);
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_valid", 32'(out_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rd_en", 32'(rd_en), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_clear", 32'(clear_fill), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("abort_post_done", 32'(done), 32'd0);
      check_eq("abort_post_clear", 32'(clear_fill), 32'd0);
    end
    fill = 8'd2; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("redrain_rd_en", 32'(rd_en), 32'(k <= 2));
      if (k <= 2) check_eq("redrain_rd_addr", 32'(rd_addr), 32'(k - 1));
      check_eq("redrain_valid", 32'(out_valid), 32'(k == 2 || k == 3));
      if (k == 2 || k == 3) check_eq("redrain_data", 32'(out_data), 32'(16 + k - 2));
      check_eq("redrain_done", 32'(done), 32'(k == 4));
    end
    repeat (2) @(negedge clk);

    // Start while busy is ignored; reset mid-drain.
    fill = 8'd5; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = (k == 3);
      fill = (k == 3) ? 8'd1 : 8'd5;
      if (k == 4) begin
        check_eq("busy_start_addr", 32'(rd_addr), 32'd3);
        check_eq("busy_start_data", 32'(out_data), 32'h12);
        check_eq("busy_start_busy", 32'(busy), 32'd1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef CACHE_DRAIN_PARITY_EN
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF;
    fill = 8'd3; start = 1'b1;
    done_seen = 1'b0;
    for (int c = 1; c <= 12 && !done_seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) check_eq("parity_clear", 32'(parity_out), 32'd0);
      if (done) begin
        done_seen = 1'b1;
        check_eq("parity_value", 32'(parity_out), 32'h66);
      end
    end
    check_eq("parity_done_seen", 32'(done_seen), 32'd1);
    @(negedge clk);
    check_eq("parity_hold", 32'(parity_out), 32'h66);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
